// File: rtl/adc_sample_packer.sv
// ============================================================================
//  Module   : adc_sample_packer
//  Purpose  : Reduces NUM_CH ADC sample streams to bytes, interleaves enabled
//             channels sample-major and packs them into OUT_W-bit beats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_packer #(
   parameter int NUM_CH   = 6,
   parameter int IN_W     = 128,
   parameter int SAMPLE_W = 32,
   parameter int OUT_W    = 128
) (
   input  logic                     ps_clk,
   input  logic                     ps_rst,
   input  logic                     start,
   input  logic                     clear,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [1:0]               mode,
   input  logic [31:0]              cap_beats,
   input  logic [NUM_CH-1:0]        s_tvalid,
   input  logic [NUM_CH*IN_W-1:0]   s_tdata,
   output logic [NUM_CH-1:0]        s_tready,
   output logic                     m_tvalid,
   output logic [OUT_W-1:0]         m_tdata,
   output logic                     m_tlast,
   input  logic                     m_tready,
   output logic                     busy,
   output logic                     done,
   output logic                     err_mask,
   output logic [31:0]              beat_cnt
);

   localparam int c_S       = IN_W / SAMPLE_W;
   localparam int c_OB      = OUT_W / 8;
   localparam int c_HALF    = SAMPLE_W / 2;
   localparam int c_GRP     = NUM_CH * c_S;
   localparam int c_CAP     = c_OB - 1 + c_GRP;
   localparam int c_CNT_W   = $clog2(c_CAP + 1);
   localparam int c_GCNT_W  = $clog2(c_GRP + 1);
   localparam logic [c_CNT_W-1:0] c_OB_CNT = c_CNT_W'(c_OB);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [NUM_CH-1:0]      r_en;
   logic [1:0]             r_mode;
   logic [31:0]            r_cap;
   logic [31:0]            r_beat_cnt;
   logic                   r_err;
   logic [c_CAP*8-1:0]     r_acc;
   logic [c_CNT_W-1:0]     r_acc_cnt;

   logic                   w_run;
   logic                   w_pop;
   logic                   w_last;
   logic                   w_fire;
   logic                   w_start_ok;
   logic                   w_to_done;
   logic                   w_flush;
   logic [NUM_CH-1:0]      w_hold_v;
   logic [c_S*8-1:0]       w_hold_b [NUM_CH];
   logic [c_GRP*8-1:0]     w_grp;
   logic [c_GCNT_W-1:0]    w_grp_cnt;
   logic [c_CAP*8-1:0]     w_acc_nxt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;
   logic                   w_unused;

   // Mode 3 is reserved and falls back to the rounded average.
   function automatic logic [7:0] f_reduce(input logic [7:0] hi_i,
                                           input logic [7:0] hi_q,
                                           input logic [1:0] md);
      case (md)
         2'd1:    return hi_i;
         2'd2:    return hi_q;
         default: return 8'(({1'b0, hi_i} + {1'b0, hi_q} + 9'd1) >> 1);
      endcase
   endfunction

   assign w_run      = (r_state == ST_RUN);
   assign m_tvalid   = w_run & (r_acc_cnt >= c_OB_CNT);
   assign m_tdata    = r_acc[OUT_W-1:0];
   assign w_last     = (r_beat_cnt == r_cap - 32'd1);
   assign m_tlast    = m_tvalid & w_last;
   assign w_pop      = m_tvalid & m_tready;
   assign w_fire     = w_run & (&(w_hold_v | ~r_en)) & (r_acc_cnt < c_OB_CNT);
   assign w_start_ok = ~clear & (r_state != ST_RUN) & start & (|ch_en);
   assign w_to_done  = w_run & ((r_cap == 32'd0) | (w_pop & w_last));
   assign w_flush    = clear | w_start_ok | w_to_done;

   assign busy       = w_run;
   assign done       = (r_state == ST_DONE);
   assign err_mask   = r_err;
   assign beat_cnt   = r_beat_cnt;
   assign w_unused   = ^s_tdata;

   // One hold register per channel, storing the already-reduced bytes.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             r_v;
      logic [c_S*8-1:0] r_b;
      logic [c_S*8-1:0] w_red;

      for (genvar s = 0; s < c_S; s++) begin : g_smp
         assign w_red[s*8 +: 8] = f_reduce(
            s_tdata[c*IN_W + s*SAMPLE_W + SAMPLE_W - 1 -: 8],
            s_tdata[c*IN_W + s*SAMPLE_W + c_HALF - 1 -: 8],
            r_mode);
      end

      assign s_tready[c] = w_run & r_en[c] & ~r_v;
      assign w_hold_v[c] = r_v;
      assign w_hold_b[c] = r_b;

      always_ff @(posedge ps_clk) begin
         if (ps_rst || w_flush) begin
            r_v <= 1'b0;
            r_b <= '0;
         end else if (s_tvalid[c] && s_tready[c]) begin
            r_v <= 1'b1;
            r_b <= w_red;
         end else if (w_fire) begin
            r_v <= 1'b0;
         end
      end
   end

   // Sample-major compaction of the enabled channels' hold bytes.
   always_comb begin
      int idx;
      idx   = 0;
      w_grp = '0;
      for (int s = 0; s < c_S; s++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (r_en[c]) begin
               w_grp[idx*8 +: 8] = w_hold_b[c][s*8 +: 8];
               idx = idx + 1;
            end
         end
      end
      w_grp_cnt = c_GCNT_W'(idx);
   end

   // Pop and push are mutually exclusive by their acc_cnt conditions.
   always_comb begin
      w_acc_nxt = r_acc;
      w_cnt_nxt = r_acc_cnt;
      if (w_pop) begin
         w_acc_nxt = r_acc >> (c_OB * 8);
         w_cnt_nxt = r_acc_cnt - c_OB_CNT;
      end else if (w_fire) begin
         for (int k = 0; k < c_GRP; k++) begin
            if (k < int'(w_grp_cnt)) begin
               w_acc_nxt[(int'(r_acc_cnt) + k)*8 +: 8] = w_grp[k*8 +: 8];
            end
         end
         w_cnt_nxt = r_acc_cnt + c_CNT_W'(w_grp_cnt);
      end
   end

   always_ff @(posedge ps_clk) begin
      if (ps_rst || w_flush) begin
         r_acc     <= '0;
         r_acc_cnt <= '0;
      end else begin
         r_acc     <= w_acc_nxt;
         r_acc_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge ps_clk) begin
      if (ps_rst) begin
         r_state    <= ST_IDLE;
         r_en       <= '0;
         r_mode     <= 2'd0;
         r_cap      <= 32'd0;
         r_beat_cnt <= 32'd0;
         r_err      <= 1'b0;
      end else if (clear) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= 32'd0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (ch_en == '0) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state    <= ST_RUN;
                     r_en       <= ch_en;
                     r_mode     <= mode;
                     r_cap      <= cap_beats;
                     r_beat_cnt <= 32'd0;
                     r_err      <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (r_cap == 32'd0) begin
                  r_state <= ST_DONE;
               end else if (w_pop) begin
                  r_beat_cnt <= r_beat_cnt + 32'd1;
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_packer.sv
// ============================================================================
//  Module   : tb_adc_sample_packer
//  Purpose  : Directed self-checking bench for adc_sample_packer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_sample_packer;

   localparam int NCH = 6;
   localparam int IW  = 128;
   localparam int SW  = 32;
   localparam int OW  = 128;

   logic             ps_clk = 1'b0;
   logic             ps_rst, start, clear, m_tready;
   logic [NCH-1:0]   ch_en, s_tvalid, s_tready;
   logic [1:0]       mode;
   logic [31:0]      cap_beats, beat_cnt;
   logic [NCH*IW-1:0] s_tdata;
   logic             m_tvalid, m_tlast, busy, done, err_mask;
   logic [OW-1:0]    m_tdata;

   int               checks = 0;
   int               failures = 0;

   logic [7:0]       tab [256];
   logic [127:0]     fixed_data [NCH];
   logic             fixed, stall, vld_rand, dis_rdy_seen;
   logic [NCH-1:0]   en_m;
   logic [1:0]       mode_m;
   logic [31:0]      cap_m;
   int               ch_k [NCH];
   int               out_beats, seed;

   adc_sample_packer #(.NUM_CH(NCH), .IN_W(IW), .SAMPLE_W(SW), .OUT_W(OW)) u_dut (
      .ps_clk(ps_clk), .ps_rst(ps_rst), .start(start), .clear(clear),
      .ch_en(ch_en), .mode(mode), .cap_beats(cap_beats),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
      .busy(busy), .done(done), .err_mask(err_mask), .beat_cnt(beat_cnt)
   );

   always #5 ps_clk = ~ps_clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] red(input logic [7:0] a, input logic [7:0] b, input logic [1:0] md);
      if (md == 2'd1) return a;
      if (md == 2'd2) return b;
      return 8'((int'(a) + int'(b) + 1) / 2);
   endfunction

   function automatic logic [31:0] gen_word(input int c, input int k, input int s);
      return {tab[(c*41 + k*7 + s*29 + seed) % 256], tab[(k*3 + s) % 256],
              tab[(c*17 + k*53 + s*3 + seed*3 + 128) % 256], tab[(c + k + s) % 256]};
   endfunction

   // Byte i of the capture: group i/(P*4), sample (i%(P*4))/P, n-th enabled channel.
   function automatic logic [127:0] exp_beat(input int b);
      logic [127:0] r;
      logic [31:0]  w;
      int p, i, g, rr, s, n, c, cnt;
      r = '0;
      p = $countones(en_m);
      if (p == 0) return r;
      for (int j = 0; j < 16; j++) begin
         i = b*16 + j; g = i / (p*4); rr = i % (p*4); s = rr / p; n = rr % p;
         c = 0; cnt = 0;
         for (int q = 0; q < NCH; q++) begin
            if (en_m[q]) begin
               if (cnt == n) c = q;
               cnt++;
            end
         end
         w = fixed ? fixed_data[c][s*32 +: 32] : gen_word(c, g, s);
         r[j*8 +: 8] = red(w[31:24], w[15:8], mode_m);
      end
      return r;
   endfunction

   task automatic drive_inputs(input logic [NCH-1:0] hs);
      for (int c = 0; c < NCH; c++) begin
         if (!(s_tvalid[c] && !hs[c]))
            s_tvalid[c] = vld_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
         s_tdata[c*IW +: IW] = fixed ? fixed_data[c] :
            {gen_word(c, ch_k[c], 3), gen_word(c, ch_k[c], 2),
             gen_word(c, ch_k[c], 1), gen_word(c, ch_k[c], 0)};
      end
      m_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
   endtask

   task automatic tick();
      logic [NCH-1:0] hs;
      logic           mhs, held;
      logic [127:0]   held_data;
      hs        = s_tvalid & s_tready;
      mhs       = m_tvalid & m_tready;
      held      = m_tvalid & ~m_tready & ~clear & ~ps_rst;
      held_data = m_tdata;
      if (mhs) begin
         chk("beat_data", m_tdata, exp_beat(out_beats));
         chk("beat_tlast", m_tlast, (32'(out_beats) == cap_m - 32'd1));
      end
      @(posedge ps_clk); #1;
      for (int c = 0; c < NCH; c++) if (hs[c]) ch_k[c]++;
      if (mhs) out_beats++;
      if (held) begin
         chk("stall_tvalid", m_tvalid, 1);
         chk("stall_tdata", m_tdata, held_data);
      end
      if ((s_tready & ~en_m) != '0) dis_rdy_seen = 1'b1;
      drive_inputs(hs);
   endtask

   task automatic do_start(input logic [NCH-1:0] en, input logic [1:0] md, input logic [31:0] cap);
      en_m = en; mode_m = md; cap_m = cap; out_beats = 0;
      for (int c = 0; c < NCH; c++) ch_k[c] = 0;
      ch_en = en; mode = md; cap_beats = cap; start = 1'b1;
      drive_inputs('0);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n = 0;
      while (!m_tvalid && n < budget) begin tick(); n++; end
      chk(tag, m_tvalid, 1);
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int n = 0;
      while (!done && n < budget) begin tick(); n++; end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_beats"}, 128'(out_beats), 128'(cap_m));
      chk({tag, "_beat_cnt"}, beat_cnt, cap_m);
      chk({tag, "_tvalid_low"}, m_tvalid, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) tab[i] = 8'($urandom_range(0, 255));
      for (int c = 0; c < NCH; c++) begin fixed_data[c] = {32{4'h5}}; ch_k[c] = 0; end
      ps_rst = 1'b1; start = 1'b0; clear = 1'b0; ch_en = '0; mode = 2'd0; cap_beats = 32'd0;
      s_tvalid = '0; s_tdata = '0; m_tready = 1'b1;
      fixed = 1'b0; stall = 1'b0; vld_rand = 1'b0; dis_rdy_seen = 1'b0;
      en_m = '0; mode_m = 2'd0; cap_m = 32'd0; out_beats = 0; seed = 0;
      repeat (3) @(posedge ps_clk);
      #1 ps_rst = 1'b0;

      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_mask", err_mask, 0);
      chk("rst_beat_cnt", beat_cnt, 0);

      // Start with no channels enabled.
      do_start('0, 2'd0, 32'd5);
      chk("err_set", err_mask, 1);
      chk("err_idle_busy", busy, 0);
      tick();
      chk("err_stays_idle", busy, 0);
      chk("err_sticky", err_mask, 1);

      // Mode 0 rounding, one channel, one beat.
      fixed = 1'b1;
      fixed_data[0] = {32'hFE00FF00, 32'h01000000, 32'h01000200, 32'hFF120034};
      do_start(6'h01, 2'd0, 32'd1);
      chk("err_cleared", err_mask, 0);
      chk("start_busy", busy, 1);
      wait_valid(50, "round_valid");
      chk("round_tdata", m_tdata, {4{32'hFF010280}});
      chk("round_tlast", m_tlast, 1);
      run_until_done(50, "round");

      // Mode 2 takes the Q high byte.
      fixed_data[0] = {4{32'h12347E56}};
      do_start(6'h01, 2'd2, 32'd1);
      wait_valid(50, "q_valid");
      chk("q_tdata", m_tdata, {16{8'h7E}});
      run_until_done(50, "q");

      // Sparse mask 0x05, mode 1.
      fixed_data[0] = {32{4'h3}};
      fixed_data[2] = {32{4'hA}};
      dis_rdy_seen = 1'b0;
      do_start(6'h05, 2'd1, 32'd4);
      wait_valid(50, "sparse_valid");
      chk("sparse_tdata", m_tdata, {8{16'hAA33}});
      chk("sparse_tlast_first", m_tlast, 0);
      run_until_done(100, "sparse");
      chk("sparse_disabled_tready", dis_rdy_seen, 0);

      // Zero-length capture.
      fixed = 1'b0; seed = 7;
      do_start(6'h3F, 2'd0, 32'd0);
      chk("zero_busy", busy, 1);
      chk("zero_tvalid_run", m_tvalid, 0);
      tick();
      chk("zero_done", done, 1);
      chk("zero_tvalid", m_tvalid, 0);
      chk("zero_beat_cnt", beat_cnt, 0);

      // Clear after 10 of 100 beats, then a fresh short capture.
      seed = 1; stall = 1'b1;
      do_start(6'h3F, 2'd0, 32'd100);
      for (int n = 0; n < 500 && out_beats < 10; n++) tick();
      chk("clr_reached_10", 128'(out_beats), 128'd10);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy", busy, 0);
      chk("clr_tvalid", m_tvalid, 0);
      chk("clr_beat_cnt", beat_cnt, 0);
      chk("clr_done", done, 0);
      chk("clr_s_tready", s_tready, 0);
      seed = 2;
      do_start(6'h3F, 2'd3, 32'd2);
      run_until_done(100, "after_clr");

      // Long six-channel capture with stalls; first-beat latency is two edges.
      seed = 3; stall = 1'b0; vld_rand = 1'b0;
      do_start(6'h3F, 2'd0, 32'd1500);
      tick();
      chk("lat_hs_edge", m_tvalid, 0);
      tick();
      chk("lat_fire_edge", m_tvalid, 1);
      stall = 1'b1; vld_rand = 1'b1;
      run_until_done(20000, "long");

      // Reset in the middle of a capture.
      seed = 4;
      do_start(6'h3F, 2'd1, 32'd50);
      repeat (20) tick();
      ps_rst = 1'b1;
      tick();
      ps_rst = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_tvalid", m_tvalid, 0);
      chk("mrst_tdata", m_tdata, 0);
      chk("mrst_beat_cnt", beat_cnt, 0);
      chk("mrst_s_tready", s_tready, 0);
      chk("mrst_done", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
